reset_sequencer: RTL and testbench

// - Generates and sequences the reset outputs that downstream sync_reset

---
 rtl/reset_sequencer.sv | 176 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Holds STAGES reset outputs until PLL lock has been stable, then releases them in index order.
// Define RESET_SEQ_RETRY_EN to retry on a stage timeout instead of parking in FAULT.
module reset_sequencer #(
    parameter int STAGES         = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    input  logic              req,
    input  logic [STAGES-1:0] stage_ready,
    output logic [STAGES-1:0] rst_out,
    output logic              done,
    output logic              busy,
    output logic              timeout
);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TW      = $clog2(TIMEOUT_CYCLES);
    localparam int KW      = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST       = KW'(STAGES - 1);

`ifdef RESET_SEQ_RETRY_EN
    typedef enum logic [2:0] {ST_HOLD, ST_WAIT, ST_GAP, ST_DONE} state_t;
`else
    typedef enum logic [2:0] {ST_HOLD, ST_WAIT, ST_GAP, ST_DONE, ST_FAULT} state_t;
`endif

    state_t            state_q, state_d;
    logic              locked_meta_q, locked_s_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [KW-1:0]     k_q, k_d, k_next;
    logic [STAGES-1:0] rst_out_q, rst_out_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic              ready_k;
    logic              restart;

    assign k_next  = k_q + KW'(1);
    assign ready_k = stage_ready[k_q];

    // FAULT is left only by req; a lock drop there is deliberately ignored.
`ifdef RESET_SEQ_RETRY_EN
    assign restart = req || !locked_s_q;
`else
    assign restart = req || (!locked_s_q && state_q != ST_FAULT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            k_q           <= '0;
            rst_out_q     <= '1;
            done_q        <= 1'b0;
            busy_q        <= 1'b1;
            timeout_q     <= 1'b0;
        end else begin
            locked_meta_q <= locked;
            locked_s_q    <= locked_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
            k_q           <= k_d;
            rst_out_q     <= rst_out_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        k_d       = k_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
        busy_d    = busy_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_HOLD: begin
                if (locked_s_q) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d   = ST_WAIT;
                        cnt_d     = '0;
                        tcnt_d    = '0;
                        k_d       = '0;
                        rst_out_d = {STAGES{1'b1}} & ~STAGES'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (ready_k) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end
                end else if (tcnt_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
`ifdef RESET_SEQ_RETRY_EN
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    tcnt_d    = '0;
                    k_d       = '0;
                    rst_out_d = '1;
`else
                    state_d   = ST_FAULT;
                    rst_out_d = '1;
`endif
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d   = ST_WAIT;
                    k_d       = k_next;
                    tcnt_d    = '0;
                    rst_out_d = rst_out_q & ~(STAGES'(1) << k_next);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                rst_out_d = '0;
            end
`ifndef RESET_SEQ_RETRY_EN
            ST_FAULT: begin
                rst_out_d = '1;
                done_d    = 1'b0;
                busy_d    = 1'b1;
            end
`endif
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        // Restart overrides everything decided above, including a coincident timeout.
        if (restart) begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            tcnt_d    = '0;
            k_d       = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
            busy_d    = 1'b1;
            timeout_d = timeout_q;
        end
    end

    assign rst_out = rst_out_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with STAGES=3, HOLD=4, GAP=2, TIMEOUT=8.
module tb_reset_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       req = 1'b0;
    logic [2:0] stage_ready = 3'b000;
    logic [2:0] rst_out;
    logic       done, busy, timeout;

    int checks = 0;
    int failures = 0;

    reset_sequencer #(
        .STAGES(3), .HOLD_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .locked(locked), .req(req), .stage_ready(stage_ready),
        .rst_out(rst_out), .done(done), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold rst, then drop it on a falling edge so the next rising edge is edge 1.
    task automatic do_reset(input logic lk, input logic [2:0] rdy);
        rst = 1'b1; locked = lk; stage_ready = rdy; req = 1'b0;
        tick(2);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; locked = 1'b1; stage_ready = 3'b111;
        tick(2);
        checks++; if (rst_out !== 3'b111) begin failures++; $display("FAIL reset_rst_out got=%b exp=111", rst_out); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        $display("test_reset: rst_out=%b done=%b busy=%b timeout=%b", rst_out, done, busy, timeout);
    endtask

    task automatic test_nominal();
        do_reset(1'b1, 3'b111);
        tick(5);
        checks++; if (rst_out !== 3'b111) begin failures++; $display("FAIL nom_e5 got=%b exp=111", rst_out); end
        tick(1);
        checks++; if (rst_out !== 3'b110) begin failures++; $display("FAIL nom_e6 got=%b exp=110", rst_out); end
        tick(2);
        checks++; if (rst_out !== 3'b110) begin failures++; $display("FAIL nom_e8 got=%b exp=110", rst_out); end
        tick(1);
        checks++; if (rst_out !== 3'b100) begin failures++; $display("FAIL nom_e9 got=%b exp=100", rst_out); end
        tick(3);
        checks++; if (rst_out !== 3'b000 || done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL nom_e12 got=%b/%b/%b exp=000/0/1", rst_out, done, busy); end
        tick(1);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL nom_done got=%b/%b exp=1/0", done, busy); end
        stage_ready = 3'b000;
        tick(3);
        checks++; if (rst_out !== 3'b000 || done !== 1'b1) begin failures++; $display("FAIL nom_ready_drop got=%b/%b exp=000/1", rst_out, done); end
        $display("test_nominal: rst_out=%b done=%b", rst_out, done);
    endtask

    task automatic test_lock_glitch();
        do_reset(1'b1, 3'b111);
        tick(2);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(5);
        checks++; if (rst_out !== 3'b111) begin failures++; $display("FAIL glitch_e8 got=%b exp=111", rst_out); end
        tick(1);
        checks++; if (rst_out !== 3'b110) begin failures++; $display("FAIL glitch_e9 got=%b exp=110", rst_out); end
        do_reset(1'b1, 3'b111);
        tick(13);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL glitch_pre_done got=%b exp=1", done); end
        locked = 1'b0;
        tick(2);
        checks++; if (rst_out !== 3'b000) begin failures++; $display("FAIL glitch_done_e2 got=%b exp=000", rst_out); end
        tick(1);
        checks++; if (rst_out !== 3'b111 || done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL glitch_done_e3 got=%b/%b/%b exp=111/0/1", rst_out, done, busy); end
        locked = 1'b1;
        $display("test_lock_glitch: rst_out=%b done=%b", rst_out, done);
    endtask

    task automatic test_ordering();
        do_reset(1'b1, 3'b101);
        tick(12);
        checks++; if (rst_out !== 3'b100) begin failures++; $display("FAIL order_park got=%b exp=100", rst_out); end
        tick(1);
        stage_ready = 3'b111;
        tick(2);
        checks++; if (rst_out !== 3'b100) begin failures++; $display("FAIL order_e15 got=%b exp=100", rst_out); end
        tick(1);
        checks++; if (rst_out !== 3'b000) begin failures++; $display("FAIL order_e16 got=%b exp=000", rst_out); end
        tick(1);
        checks++; if (done !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL order_done got=%b/%b exp=1/0", done, timeout); end
        $display("test_ordering: rst_out=%b done=%b", rst_out, done);
    endtask

    task automatic test_req_collision();
        do_reset(1'b1, 3'b000);
        tick(7);
        checks++; if (rst_out !== 3'b110) begin failures++; $display("FAIL coll_wait got=%b exp=110", rst_out); end
        stage_ready = 3'b001; req = 1'b1;
        tick(1);
        req = 1'b0;
        checks++; if (rst_out !== 3'b111 || busy !== 1'b1) begin failures++; $display("FAIL coll_restart got=%b/%b exp=111/1", rst_out, busy); end
        tick(4);
        checks++; if (rst_out !== 3'b110) begin failures++; $display("FAIL coll_rerelease got=%b exp=110", rst_out); end
        $display("test_req_collision: rst_out=%b", rst_out);
    endtask

    task automatic test_timeout();
        do_reset(1'b1, 3'b000);
        tick(13);
        checks++; if (timeout !== 1'b0 || rst_out !== 3'b110) begin failures++; $display("FAIL to_e13 got=%b/%b exp=0/110", timeout, rst_out); end
        tick(1);
        checks++; if (timeout !== 1'b1 || rst_out !== 3'b111 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL to_e14 got=%b/%b/%b/%b exp=1/111/1/0", timeout, rst_out, busy, done); end
`ifdef RESET_SEQ_RETRY_EN
        tick(4);
        checks++; if (rst_out !== 3'b110 || timeout !== 1'b1) begin failures++; $display("FAIL to_retry_rel got=%b/%b exp=110/1", rst_out, timeout); end
        tick(8);
        checks++; if (rst_out !== 3'b111) begin failures++; $display("FAIL to_retry_again got=%b exp=111", rst_out); end
`else
        locked = 1'b0;
        tick(4);
        locked = 1'b1;
        tick(10);
        checks++; if (rst_out !== 3'b111 || timeout !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL to_fault_park got=%b/%b/%b exp=111/1/1", rst_out, timeout, busy); end
        req = 1'b1;
        tick(1);
        req = 1'b0;
        tick(3);
        checks++; if (rst_out !== 3'b111) begin failures++; $display("FAIL to_fault_req_e3 got=%b exp=111", rst_out); end
        tick(1);
        checks++; if (rst_out !== 3'b110 || timeout !== 1'b1) begin failures++; $display("FAIL to_fault_req_e4 got=%b/%b exp=110/1", rst_out, timeout); end
`endif
        $display("test_timeout: rst_out=%b timeout=%b", rst_out, timeout);
    endtask

    task automatic test_async_rst();
        locked = 1'b1; stage_ready = 3'b111;
        req = 1'b1;
        tick(1);
        req = 1'b0;
        tick(5);
        checks++; if (rst_out !== 3'b110 || timeout !== 1'b1) begin failures++; $display("FAIL async_gap got=%b/%b exp=110/1", rst_out, timeout); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rst_out !== 3'b111 || done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL async_rst got=%b/%b/%b/%b exp=111/0/1/0", rst_out, done, busy, timeout); end
        @(negedge clk);
        rst = 1'b0;
        tick(6);
        checks++; if (rst_out !== 3'b110) begin failures++; $display("FAIL async_recover got=%b exp=110", rst_out); end
        $display("test_async_rst: rst_out=%b timeout=%b", rst_out, timeout);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_ordering();
        test_req_collision();
        test_timeout();
        test_async_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
